// File: rtl/mid_side_pkg.sv
// Shared Mid/Side types and helpers, used by both the encoder and decoder paths.
package mid_side_pkg;

  localparam int W = 16;

  typedef logic signed [W-1:0] sample_t;
  typedef logic signed [W:0]   wide_t;

  typedef struct packed {
    sample_t val;
    logic    clip;
  } sat_t;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_DECODE = 1'b1
  } mode_e;

  // Clamp a W+1-bit value into W bits; clip reports whether clamping happened.
  function automatic sat_t sat_w(input wide_t x);
    sat_t r;
    r.clip = x[W] ^ x[W-1];
    r.val  = x[W-1:0];
    if (r.clip) begin
      r.val = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/ms_sat.sv
// Combinational W+1 -> W bit signed saturator with clip flag.
module ms_sat #(
  parameter int W = 16
) (
  input  logic signed [W:0]   din,
  output logic signed [W-1:0] dout,
  output logic                clip
);

  // Overflow shows as disagreement between the two top bits; clamp toward the sign.
  always_comb begin
    clip = din[W] ^ din[W-1];
    dout = din[W-1:0];
    if (clip) begin
      dout = din[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mid_side_decoder.sv
// Streaming Mid/Side -> Left/Right decoder: 2-stage valid/ready pipeline,
// saturating reconstruction and a saturating clip-event counter.
module mid_side_decoder #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] mid_in,
  input  logic signed [W-1:0] side_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] L_out,
  output logic signed [W-1:0] R_out,
  output logic                clip,
  input  logic                sat_clr,
  output logic [CNT_W-1:0]    clip_cnt
);

  import mid_side_pkg::*;

  // Stage 1 state
  logic                v1;
  mode_e               en1;
  logic signed [W:0]   sum1;
  logic signed [W:0]   diff1;
  logic signed [W-1:0] mid1;
  logic signed [W-1:0] side1;

  // Stage 2 valid (data lives directly in the output registers)
  logic v2;

  logic signed [W:0]   mid_x;
  logic signed [W:0]   side_x;
  logic signed [W-1:0] sat_l;
  logic signed [W-1:0] sat_r;
  logic                clip_l;
  logic                clip_r;

  logic                s2_load;
  logic                accept;
  logic signed [W-1:0] l_nxt;
  logic signed [W-1:0] r_nxt;
  logic                clip_nxt;

  assign mid_x  = {mid_in[W-1], mid_in};
  assign side_x = {side_in[W-1], side_in};

  // s_ready depends combinationally on m_ready through s2_load, so a full
  // pipeline can still take a new beat in the same cycle the output drains.
  assign s2_load = ce & v1 & (~v2 | m_ready);
  assign s_ready = ce & (~v1 | s2_load);
  assign accept  = s_valid & s_ready;
  assign m_valid = v2;

  ms_sat #(.W(W)) u_sat_l (
    .din  (sum1),
    .dout (sat_l),
    .clip (clip_l)
  );

  ms_sat #(.W(W)) u_sat_r (
    .din  (diff1),
    .dout (sat_r),
    .clip (clip_r)
  );

  // Select decoded or bypassed values for the next S2 load.
  always_comb begin
    l_nxt    = mid1;
    r_nxt    = side1;
    clip_nxt = 1'b0;
    if (en1 == MODE_DECODE) begin
      l_nxt    = sat_l;
      r_nxt    = sat_r;
      clip_nxt = clip_l | clip_r;
    end
  end

  // Stage 1: capture exact sum/difference plus raw copies for bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      en1   <= MODE_BYPASS;
      sum1  <= '0;
      diff1 <= '0;
      mid1  <= '0;
      side1 <= '0;
    end else if (accept) begin
      v1    <= 1'b1;
      en1   <= mode_e'(enable);
      sum1  <= mid_x + side_x;
      diff1 <= mid_x - side_x;
      mid1  <= mid_in;
      side1 <= side_in;
    end else if (s2_load) begin
      v1 <= 1'b0;
    end
  end

  // Stage 2: registered outputs, held while stalled or while ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      L_out <= '0;
      R_out <= '0;
      clip  <= 1'b0;
    end else if (s2_load) begin
      v2    <= 1'b1;
      L_out <= l_nxt;
      R_out <= r_nxt;
      clip  <= clip_nxt;
    end else if (ce && m_ready) begin
      v2 <= 1'b0;
    end
  end

  // Clip-event counter: clear wins over increment, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt <= '0;
    end else if (ce) begin
      if (sat_clr) begin
        clip_cnt <= '0;
      end else if (s2_load && clip_nxt && (clip_cnt != '1)) begin
        clip_cnt <= clip_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mid_side_decoder.sv
// Directed self-checking bench for mid_side_decoder.
module tb_mid_side_decoder;

  logic               clk;
  logic               rst_n;
  logic               ce;
  logic               enable;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] mid_in;
  logic signed [15:0] side_in;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] L_out;
  logic signed [15:0] R_out;
  logic               clip;
  logic               sat_clr;
  logic [15:0]        clip_cnt;

  int total = 0;
  int bad   = 0;

  mid_side_decoder #(.W(16), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .enable   (enable),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .mid_in   (mid_in),
    .side_in  (side_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .L_out    (L_out),
    .R_out    (R_out),
    .clip     (clip),
    .sat_clr  (sat_clr),
    .clip_cnt (clip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipe with m_ready=1; result is on the outputs afterwards.
  task automatic send1(input int m, input int s, input logic en);
    s_valid = 1'b1;
    mid_in  = 16'(m);
    side_in = 16'(s);
    enable  = en;
    step();
    s_valid = 1'b0;
    step();
  endtask

  int bm [8] = '{1000, -5000, 20000, 7, -20000, 1, -32768, 12345};
  int bs [8] = '{200, -3000, 20000, -7, 20000, 1, -32768, -345};
  int be [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
  int el [8] = '{1200, -8000, 32767, 7, 0, 2, -32768, 12000};
  int er [8] = '{800, -2000, 0, -7, -32768, 0, 0, 12690};
  int ec [8] = '{0, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    int sent;
    int got;
    logic pstall;
    logic signed [15:0] pl;
    logic signed [15:0] pr;
    int lv;
    int rv;
    int me;
    int se;

    rst_n   = 1'b0;
    ce      = 1'b1;
    enable  = 1'b1;
    s_valid = 1'b0;
    mid_in  = '0;
    side_in = '0;
    m_ready = 1'b1;
    sat_clr = 1'b0;
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_L", L_out, 0);
    chk("rst_R", R_out, 0);
    chk("rst_clip", clip, 0);
    chk("rst_cnt", clip_cnt, 0);
    chk("rst_s_ready", s_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    // Decode, no stall: one result per cycle, one cycle after acceptance
    s_valid = 1'b1; mid_in = 16'(1500); side_in = 16'(500); enable = 1'b1;
    step();
    chk("t1_first_pending", m_valid, 0);
    mid_in = 16'(0); side_in = 16'(-2000);
    step();
    chk("t1_a_valid", m_valid, 1);
    chk("t1_a_L", L_out, 2000);
    chk("t1_a_R", R_out, 1000);
    chk("t1_a_clip", clip, 0);
    mid_in = 16'(25); side_in = 16'(75);
    step();
    chk("t1_b_L", L_out, -2000);
    chk("t1_b_R", R_out, 2000);
    s_valid = 1'b0;
    step();
    chk("t1_c_valid", m_valid, 1);
    chk("t1_c_L", L_out, 100);
    chk("t1_c_R", R_out, -50);
    chk("t1_c_clip", clip, 0);
    step();
    chk("t1_drained", m_valid, 0);

    // Saturation and clip counter
    send1(32767, 32767, 1'b1);
    chk("t2_pos_L", L_out, 32767);
    chk("t2_pos_R", R_out, 0);
    chk("t2_pos_clip", clip, 1);
    send1(-32768, 32767, 1'b1);
    chk("t2_neg_L", L_out, -1);
    chk("t2_neg_R", R_out, -32768);
    chk("t2_neg_clip", clip, 1);
    step();
    chk("t2_cnt", clip_cnt, 2);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("t2_cnt_clr", clip_cnt, 0);

    // Bypass
    send1(32767, -32768, 1'b0);
    chk("t3_byp_L", L_out, 32767);
    chk("t3_byp_R", R_out, -32768);
    chk("t3_byp_clip", clip, 0);
    chk("t3_byp_cnt", clip_cnt, 0);

    // Mixed enable, back to back
    s_valid = 1'b1; mid_in = 16'(100); side_in = 16'(50); enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    chk("t3_mix0_L", L_out, 150);
    chk("t3_mix0_R", R_out, 50);
    enable = 1'b1;
    step();
    chk("t3_mix1_L", L_out, 100);
    chk("t3_mix1_R", R_out, 50);
    s_valid = 1'b0;
    step();
    chk("t3_mix2_L", L_out, 150);
    chk("t3_mix2_R", R_out, 50);
    step();

    // Backpressure: two beats fill the pipe, third is refused
    m_ready = 1'b0;
    s_valid = 1'b1; mid_in = 16'(10); side_in = 16'(5); enable = 1'b1;
    step();
    mid_in = 16'(-10); side_in = 16'(5);
    step();
    mid_in = 16'(1); side_in = 16'(2);
    #1;
    chk("t4_full_s_ready", s_ready, 0);
    chk("t4_full_valid", m_valid, 1);
    chk("t4_full_L", L_out, 15);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_hold_L", L_out, 15);
      chk("t4_hold_R", R_out, 5);
      chk("t4_hold_s_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    chk("t4_y_valid", m_valid, 1);
    chk("t4_y_L", L_out, -5);
    chk("t4_y_R", R_out, -15);
    step();
    chk("t4_no_dup", m_valid, 0);

    // Backpressure: random m_ready, 8 beats against the hand table
    sent = 0;
    got = 0;
    pstall = 1'b0;
    pl = '0;
    pr = '0;
    for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
      if (sent < 8) begin
        s_valid = 1'b1;
        mid_in  = 16'(bm[sent]);
        side_in = 16'(bs[sent]);
        enable  = 1'(be[sent]);
      end else begin
        s_valid = 1'b0;
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (pstall) begin
        chk("t4_stall_valid", m_valid, 1);
        chk("t4_stall_L", L_out, pl);
        chk("t4_stall_R", R_out, pr);
      end
      if (s_valid && s_ready) sent++;
      if (m_valid && m_ready) begin
        chk("t4_seq_L", L_out, el[got]);
        chk("t4_seq_R", R_out, er[got]);
        chk("t4_seq_clip", clip, ec[got]);
        got++;
      end
      pstall = m_valid & ~m_ready;
      pl = L_out;
      pr = R_out;
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("t4_seq_count", got, 8);
    chk("t4_cnt", clip_cnt, 3);
    step();

    // ce low freezes everything
    m_ready = 1'b0;
    s_valid = 1'b1; mid_in = 16'(30000); side_in = 16'(30000); enable = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    chk("t5_pre_valid", m_valid, 1);
    chk("t5_pre_cnt", clip_cnt, 4);
    ce = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1; mid_in = 16'(5); side_in = 16'(5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_ce_valid", m_valid, 1);
      chk("t5_ce_L", L_out, 32767);
      chk("t5_ce_clip", clip, 1);
      chk("t5_ce_cnt", clip_cnt, 4);
      chk("t5_ce_s_ready", s_ready, 0);
    end
    ce = 1'b1;
    s_valid = 1'b0;
    step();
    chk("t5_ce_resume_drain", m_valid, 0);

    // Asynchronous reset with two beats in flight
    m_ready = 1'b0;
    s_valid = 1'b1; mid_in = 16'(-30000); side_in = 16'(-30000);
    step();
    mid_in = 16'(4); side_in = 16'(2);
    step();
    s_valid = 1'b0;
    chk("t5_inflight_cnt", clip_cnt, 5);
    chk("t5_inflight_valid", m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_cnt", clip_cnt, 0);
    chk("t5_rst_L", L_out, 0);
    #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    step();
    chk("t5_rst_no_ghost", m_valid, 0);
    send1(1500, 500, 1'b1);
    chk("t5_resume_L", L_out, 2000);
    chk("t5_resume_R", R_out, 1000);
    step();
    chk("t5_resume_single", m_valid, 0);

    // Round trip through the encoder equations: mid=(L+R)>>>1, side=(L-R)>>>1
    lv = 3; rv = 0;
    me = (lv + rv) >>> 1; se = (lv - rv) >>> 1;
    send1(me, se, 1'b1);
    chk("t6_odd_L", L_out, 2);
    chk("t6_odd_R", R_out, 0);
    lv = 100; rv = -40;
    me = (lv + rv) >>> 1; se = (lv - rv) >>> 1;
    send1(me, se, 1'b1);
    chk("t6_even1_L", L_out, 100);
    chk("t6_even1_R", R_out, -40);
    lv = -7; rv = 5;
    me = (lv + rv) >>> 1; se = (lv - rv) >>> 1;
    send1(me, se, 1'b1);
    chk("t6_even2_L", L_out, -7);
    chk("t6_even2_R", R_out, 5);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
